// File: rtl/fetch_decode_pipe.sv
// fetch_decode_pipe: PC register, next-PC select and IF/ID pipeline register
// for the front end of the 5-stage pipeline. Instruction memory is external
// and combinational (instrF is the word at pcF in the same cycle).
// Optional feature macro: PERF_CNT_EN enables saturating decode stall/flush
// counters; without it stall_cnt and flush_cnt are tied to 0.
module fetch_decode_pipe #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            pcsrcE,
    input  logic [XLEN-1:0] pctargetE,
    input  logic [31:0]     instrF,
    output logic [XLEN-1:0] pcF,
    output logic [31:0]     instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcplus4D,
    output logic            validD,
    output logic [4:0]      rs1D,
    output logic [4:0]      rs2D,
    output logic [4:0]      rdD,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
);

    localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pcd_q, pcd_d;
    logic [XLEN-1:0] pcp4_q, pcp4_d;
    logic            valid_q, valid_d;

    // Next-PC select: redirect beats stall, otherwise sequential (wraps mod 2^XLEN)
    always_comb begin
        pc_d = pc_q;
        if (pcsrcE) begin
            pc_d = pctargetE & ALIGN_MASK;
        end else if (!stallF) begin
            pc_d = pc_q + INSTR_BYTES;
        end
    end

    // IF/ID next state: flush inserts a bubble and beats stall
    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (flushD) begin
            instr_d = NOP_INSTR;
            pcd_d   = '0;
            pcp4_d  = '0;
            valid_d = 1'b0;
        end else if (!stallD) begin
            instr_d = instrF;
            pcd_d   = pc_q;
            pcp4_d  = pc_q + INSTR_BYTES;
            valid_d = 1'b1;
        end
    end

    // PC and IF/ID registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcd_q   <= '0;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters of decode stall and flush cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stallD && !flushD && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flushD && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    assign pcF      = pc_q;
    assign instrD   = instr_q;
    assign pcD      = pcd_q;
    assign pcplus4D = pcp4_q;
    assign validD   = valid_q;

    // Register specifiers decoded straight from the IF/ID instruction
    assign rs1D = instr_q[19:15];
    assign rs2D = instr_q[24:20];
    assign rdD  = instr_q[11:7];

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Self-checking bench for fetch_decode_pipe: directed scenarios plus a
// randomized hazard-control phase, checked against a register-level model.
module tb_fetch_decode_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF, stallD, flushD, pcsrcE;
    logic [31:0] pctargetE;
    logic [31:0] instrF;
    logic [31:0] pcF, instrD, pcD, pcplus4D;
    logic        validD;
    logic [4:0]  rs1D, rs2D, rdD;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int fails  = 0;

    // Model state
    logic [31:0] m_pc, m_instr, m_pcd, m_p4;
    logic        m_valid;
    longint      m_stalls, m_flushes;
    logic [31:0] key = 32'hA5A5_0000;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ key;
    endfunction

    assign instrF = imem(pcF);

    fetch_decode_pipe dut (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .pcsrcE(pcsrcE), .pctargetE(pctargetE), .instrF(instrF), .pcF(pcF),
        .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D), .validD(validD),
        .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h13; m_pcd = 0; m_p4 = 0; m_valid = 0;
        m_stalls = 0; m_flushes = 0;
    endtask

    function automatic logic [31:0] sat(input longint n);
        return (n > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : n[31:0];
    endfunction

    task automatic check_all(input string ph);
        chk({ph, "_pcF"}, pcF, m_pc);
        chk({ph, "_instrD"}, instrD, m_instr);
        chk({ph, "_pcD"}, pcD, m_pcd);
        chk({ph, "_pcplus4D"}, pcplus4D, m_p4);
        chk({ph, "_validD"}, {31'b0, validD}, {31'b0, m_valid});
        chk({ph, "_regs"}, {17'b0, rs1D, rs2D, rdD},
            {17'b0, m_instr[19:15], m_instr[24:20], m_instr[11:7]});
`ifdef PERF_CNT_EN
        chk({ph, "_stall_cnt"}, stall_cnt, sat(m_stalls));
        chk({ph, "_flush_cnt"}, flush_cnt, sat(m_flushes));
`else
        chk({ph, "_stall_cnt"}, stall_cnt, 32'h0);
        chk({ph, "_flush_cnt"}, flush_cnt, 32'h0);
`endif
    endtask

    // One clock edge: advance the model from the current inputs, then compare
    task automatic step(input string ph);
        logic [31:0] fetched;
        fetched = imem(m_pc);
        if (flushD) begin
            m_instr = 32'h13; m_pcd = 0; m_p4 = 0; m_valid = 0;
        end else if (!stallD) begin
            m_instr = fetched; m_pcd = m_pc; m_p4 = m_pc + 32'd4; m_valid = 1;
        end
        if (stallD && !flushD) m_stalls++;
        if (flushD) m_flushes++;
        if (pcsrcE) m_pc = {pctargetE[31:2], 2'b00};
        else if (!stallF) m_pc = m_pc + 32'd4;
        @(posedge clk); #1;
        check_all(ph);
    endtask

    task automatic set_in(input logic sf, input logic sd, input logic fd,
                          input logic ps, input logic [31:0] tgt);
        stallF = sf; stallD = sd; flushD = fd; pcsrcE = ps; pctargetE = tgt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // T2: free run, instrD lags pcF by one cycle
        for (int i = 0; i < 16; i++) step("t2");
        chk("t2_pc_at_0x40", pcF, 32'h40);
        chk("t2_instrD_word3c", instrD, 32'h3C ^ 32'hA5A5_0000);
        chk("t2_pcplus4", pcplus4D, pcD + 32'd4);

        // T1: asynchronous reset mid-run, visible without a clock edge
        rst = 1'b1;
        #2;
        chk("t1_pcF", pcF, 32'h0);
        chk("t1_instrD", instrD, 32'h13);
        chk("t1_validD", {31'b0, validD}, 32'h0);
        chk("t1_pcD", pcD, 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        check_all("t1_hold");

        // T3: one load-use stall at pcF=8
        step("t3"); step("t3");
        chk("t3_pre_pc", pcF, 32'h8);
        set_in(1, 1, 0, 0, 32'h0);
        step("t3_stall");
        chk("t3_pc_held", pcF, 32'h8);
        chk("t3_instr_held", instrD, 32'h4 ^ 32'hA5A5_0000);
        set_in(0, 0, 0, 0, 32'h0);
        step("t3_after");
        chk("t3_instr_next", instrD, 32'h8 ^ 32'hA5A5_0000);

        // T4: redirect with flush; target alignment
        set_in(0, 0, 1, 1, 32'h103);
        step("t4_redir");
        chk("t4_pc", pcF, 32'h100);
        chk("t4_bubble", instrD, 32'h13);
        chk("t4_valid", {31'b0, validD}, 32'h0);
        set_in(0, 0, 0, 0, 32'h0);
        step("t4_after");
        chk("t4_target_word", instrD, 32'h100 ^ 32'hA5A5_0000);

        // T5: redirect beats stallF, flush beats stallD
        set_in(1, 1, 1, 1, 32'h200);
        step("t5");
        chk("t5_pc", pcF, 32'h200);
        chk("t5_bubble", instrD, 32'h13);
        set_in(0, 0, 0, 0, 32'h0);
        step("t5_after");

        // T6: PC wrap, then counter accumulation from a fresh reset
        set_in(0, 0, 1, 1, 32'hFFFF_FFFF);
        step("t6_redir");
        chk("t6_pc_top", pcF, 32'hFFFF_FFFC);
        set_in(0, 0, 0, 0, 32'h0);
        step("t6_wrap");
        chk("t6_pc_wrapped", pcF, 32'h0);
        chk("t6_pcplus4_wrap", pcplus4D, 32'h0);
        do_reset();
        set_in(1, 1, 0, 0, 32'h0);
        repeat (3) step("t6_stall");
        set_in(0, 0, 1, 0, 32'h0);
        repeat (2) step("t6_flush");
`ifdef PERF_CNT_EN
        chk("t6_stall_cnt3", stall_cnt, 32'd3);
        chk("t6_flush_cnt2", flush_cnt, 32'd2);
`else
        chk("t6_stall_cnt0", stall_cnt, 32'd0);
        chk("t6_flush_cnt0", flush_cnt, 32'd0);
`endif

        // Randomized hazard control against the model
        set_in(0, 0, 0, 0, 32'h0);
        key = $urandom;
        for (int i = 0; i < 400; i++) begin
            logic ps;
            ps = ($urandom_range(0, 7) == 0);
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   ps | ($urandom_range(0, 9) == 0), ps, $urandom);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
